// File: rtl/fe_tobytes.sv
// ---------------------------------------------------------------------------
// fe_tobytes
//
// Purpose:
//   Converts a GF(2^255-19) field element held as ten signed 32-bit limbs in
//   radix 2^25.5 into its canonical 32-byte little-endian encoding. The work
//   is spread over one limb per clock, so a request takes 24 cycles from
//   capture to the done pulse.
//
// Ports:
//   clk    in   1    clock, rising-edge
//   rst    in   1    asynchronous active-high reset
//   valid  in   1    request strobe, only looked at while idle
//   in     in   320  ten signed limbs, limb i at in[i*32 +: 32]
//   out    out  256  canonical encoding, byte k at out[k*8 +: 8]; held
//                    between completions
//   done   out  1    one-cycle pulse when out carries a new result
// ---------------------------------------------------------------------------
module fe_tobytes (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [319:0] in,
  output logic [255:0] out,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_QINIT  = 3'd1,
    S_QCHAIN = 3'd2,
    S_FOLD   = 3'd3,
    S_CARRY  = 3'd4,
    S_PACK   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  // Limb index shared by the QCHAIN and CARRY walks.
  logic [3:0]         r_idx;
  logic               w_lastIdx;

  logic signed [63:0] r_h [10];
  logic signed [63:0] r_q;

  logic signed [63:0] w_hSel;
  logic signed [63:0] w_qSum;
  logic signed [63:0] w_qStep;
  logic signed [63:0] w_carry;
  logic signed [63:0] w_carryShifted;
  logic signed [63:0] w_qInit;
  logic signed [63:0] w_fold;

  logic [255:0]       r_out;
  logic               r_done;
  logic [255:0]       w_packed;

  assign out  = r_out;
  assign done = r_done;

  assign w_lastIdx = (r_idx == 4'd9);

  // Select the limb currently addressed by r_idx.
  always_comb begin
    w_hSel = 64'sd0;
    for (int j = 0; j < 10; j++) begin
      if (r_idx == 4'(j)) begin
        w_hSel = r_h[j];
      end
    end
  end

  // Even limbs are 26 bits wide, odd limbs 25; r_idx[0] picks the width.
  // All shifts are arithmetic so negative limbs floor correctly.
  assign w_qSum         = w_hSel + r_q;
  assign w_qStep        = r_idx[0] ? (w_qSum >>> 25) : (w_qSum >>> 26);
  assign w_carry        = r_idx[0] ? (w_hSel >>> 25) : (w_hSel >>> 26);
  assign w_carryShifted = r_idx[0] ? (w_carry <<< 25) : (w_carry <<< 26);

  // Initial quotient estimate from the top limb: 2^255 wraps to 19, and
  // the 2^24 term rounds the estimate to nearest.
  assign w_qInit = (r_h[9] * 64'sd19 + 64'sd16777216) >>> 25;

  // Subtracting q*p is the same as adding 19*q and dropping the final
  // carry out of limb 9.
  assign w_fold  = r_h[0] + 64'sd19 * r_q;

  // After the carry pass every limb fits its width, so the encoding is a
  // plain concatenation of the low bits; bit 255 is always zero.
  assign w_packed = {1'b0,
                     r_h[9][24:0], r_h[8][25:0], r_h[7][24:0], r_h[6][25:0],
                     r_h[5][24:0], r_h[4][25:0], r_h[3][24:0], r_h[2][25:0],
                     r_h[1][24:0], r_h[0][25:0]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Unused encodings fall back to idle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (valid) w_nextState = S_QINIT;
      S_QINIT:  w_nextState = S_QCHAIN;
      S_QCHAIN: if (w_lastIdx) w_nextState = S_FOLD;
      S_FOLD:   w_nextState = S_CARRY;
      S_CARRY:  if (w_lastIdx) w_nextState = S_PACK;
      S_PACK:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= 4'd0;
      r_q    <= 64'sd0;
      r_out  <= 256'd0;
      r_done <= 1'b0;
      for (int j = 0; j < 10; j++) begin
        r_h[j] <= 64'sd0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idx <= 4'd0;
          if (valid) begin
            for (int j = 0; j < 10; j++) begin
              r_h[j] <= {{32{in[j*32+31]}}, in[j*32 +: 32]};
            end
          end
        end
        S_QINIT: begin
          r_q   <= w_qInit;
          r_idx <= 4'd0;
        end
        S_QCHAIN: begin
          r_q   <= w_qStep;
          r_idx <= w_lastIdx ? 4'd0 : r_idx + 4'd1;
        end
        S_FOLD: begin
          r_h[0] <= w_fold;
          r_idx  <= 4'd0;
        end
        S_CARRY: begin
          // Keep the low bits in the current limb and push the carry up;
          // the carry out of limb 9 is discarded.
          for (int j = 0; j < 10; j++) begin
            if (r_idx == 4'(j)) begin
              r_h[j] <= w_hSel - w_carryShifted;
            end
          end
          for (int j = 1; j < 10; j++) begin
            if (r_idx == 4'(j - 1)) begin
              r_h[j] <= r_h[j] + w_carry;
            end
          end
          r_idx <= w_lastIdx ? 4'd0 : r_idx + 4'd1;
        end
        S_PACK: begin
          r_out  <= w_packed;
          r_done <= 1'b1;
          r_idx  <= 4'd0;
        end
        default: begin
          r_idx <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fe_tobytes.sv
// ---------------------------------------------------------------------------
// tb_fe_tobytes
//
// Directed test of fe_tobytes: field elements with known canonical
// encodings, latency, back-to-back operation, valid/in changes while busy,
// and reset during a computation.
// ---------------------------------------------------------------------------
module tb_fe_tobytes;

  logic         clk;
  logic         rst;
  logic         valid;
  logic [319:0] in;
  logic [255:0] out;
  logic         done;

  int assertCount = 0;
  int failCount   = 0;

  fe_tobytes dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .in    (in),
    .out   (out),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit weights of the ten limbs.
  int wt [10] = '{0, 26, 51, 77, 102, 128, 153, 179, 204, 230};

  // Every limb set to the same value.
  function automatic logic [319:0] allLimbs(input int v);
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  // One limb set, the rest zero.
  function automatic logic [319:0] oneLimb(input int idx, input int v);
    logic [319:0] r;
    r = '0;
    r[idx*32 +: 32] = v;
    return r;
  endfunction

  // All limbs at full width except limb 0, which is given.
  function automatic logic [319:0] maxVec(input int h0v);
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = (i % 2 == 1) ? 33554431 : 67108863;
    r[31:0] = h0v;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Starts a request at the next rising edge (caller sits at a falling
  // edge), waits for done with a bounded budget, checks latency, result and
  // that done drops again. With toggle set, valid and in wiggle while busy.
  task automatic applyStimulus(input string tag, input logic [319:0] vec,
                               input logic [255:0] expOut, input bit toggle);
    int lat;
    in    = vec;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    in    = ~vec;
    lat   = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (toggle && k < 20) begin
        valid = k[0];
        in    = allLimbs(k + 1000);
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    checkOutput({tag, " latency"}, 256'(lat + 1000), 256'(23 + 1000));
    checkOutput({tag, " out"}, out, expOut);
    @(negedge clk);
    checkOutput({tag, " done pulse width"}, 256'(done), 256'd0);
  endtask

  logic [255:0] pMod;
  logic [255:0] expS;
  logic [255:0] exp27;
  logic [255:0] expA, expB, expC, expMix;
  logic [319:0] vecA, vecB, vecC, vecMix;
  logic         expDone;
  int           pulses;

  initial begin
    pMod  = (256'd1 << 255) - 256'd19;
    expS  = '0;
    exp27 = 256'd76;
    for (int i = 0; i < 10; i++) expS = expS + (256'd1 << wt[i]);
    for (int i = 0; i < 9; i++) exp27 = exp27 + (256'd1 << (wt[i] + 27));

    vecMix = oneLimb(0, 5);
    vecMix[32 +: 32]  = 32'd3;
    vecMix[160 +: 32] = -32'sd2;
    expMix = pMod + 256'd5 + (256'd3 << 26) - (256'd1 << 129);

    rst   = 1'b1;
    valid = 1'b0;
    in    = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset out", out, 256'd0);
    checkOutput("reset done", 256'(done), 256'd0);

    // Request presented on the first edge after reset release.
    rst = 1'b0;
    applyStimulus("zero", allLimbs(0), 256'd0, 1'b0);
    applyStimulus("p", maxVec(67108845), 256'd0, 1'b0);
    applyStimulus("p+1", maxVec(67108846), 256'd1, 1'b0);
    applyStimulus("2^255-1", maxVec(67108863), 256'd18, 1'b0);
    applyStimulus("h0=-1", oneLimb(0, -1), pMod - 256'd1, 1'b0);
    applyStimulus("h0=2^26", oneLimb(0, 1 << 26), 256'h4000000, 1'b0);
    applyStimulus("h9=2^25", oneLimb(9, 1 << 25), 256'd19, 1'b0);
    applyStimulus("h2=-1", oneLimb(2, -1), pMod - (256'd1 << 51), 1'b0);
    applyStimulus("all 1", allLimbs(1), expS, 1'b0);
    applyStimulus("all -1", allLimbs(-1), pMod - expS, 1'b0);
    applyStimulus("all 2^27", allLimbs(1 << 27), exp27, 1'b0);
    applyStimulus("all -2^27", allLimbs(-(1 << 27)), pMod - exp27, 1'b0);
    applyStimulus("mixed", vecMix, expMix, 1'b0);

    // Result must hold while idle.
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("hold out", out, expMix);
    checkOutput("hold no done", 256'(pulses), 256'd0);

    // valid and in toggling while busy must not disturb the result.
    applyStimulus("toggle", allLimbs(-1), pMod - expS, 1'b1);

    // Back-to-back with valid held high; in changes every cycle and only
    // the vectors present at edges 0, 24 and 48 may be captured.
    vecA = allLimbs(1);
    expA = expS;
    vecB = oneLimb(9, 1 << 25);
    expB = 256'd19;
    vecC = allLimbs(-1);
    expC = pMod - expS;
    for (int t = 0; t < 74; t++) begin
      if (t >= 1) begin
        expDone = (t == 24 || t == 48 || t == 72);
        checkOutput($sformatf("b2b done t=%0d", t), 256'(done), 256'(expDone));
        if (t == 24) checkOutput("b2b out A", out, expA);
        if (t == 48) checkOutput("b2b out B", out, expB);
        if (t == 72) checkOutput("b2b out C", out, expC);
      end
      valid = (t < 72);
      case (t)
        0:       in = vecA;
        24:      in = vecB;
        48:      in = vecC;
        default: in = allLimbs(t * 7 + 3);
      endcase
      @(negedge clk);
    end
    valid = 1'b0;

    // Reset in the middle of a computation.
    checkOutput("pre-abort out", out, expC);
    in    = allLimbs(1 << 27);
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort out", out, 256'd0);
    checkOutput("abort done", 256'(done), 256'd0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("aborted no done", 256'(pulses), 256'd0);
    applyStimulus("after abort", allLimbs(1 << 27), exp27, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fe_tobytes.md
FE_TOBYTES -- requirements
Module: fe_tobytes

Interface
REQ-001 Parameters: none; module SHALL be non-parameterized.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 valid  input  1  request strobe; sampled only in IDLE.
REQ-005 in  input  320  field element, 10 signed 32-bit limbs; limb i at in[i*32 +: 32], radix 2^25.5 (limb weights 2^0,2^26,2^51,2^77,2^102,2^128,2^153,2^179,2^204,2^230).
REQ-006 out  output  256  canonical little-endian encoding of (sum of limbs) mod p, p = 2^255-19; byte k at out[k*8 +: 8].
REQ-007 done  output  1  one-cycle pulse; out valid from this cycle until next done.

Function
REQ-008 Internal limbs h0..h9 and q SHALL be signed 64-bit; all right shifts SHALL be arithmetic (floor).
REQ-009 Limb widths SHALL be w_i = 26 for even i, 25 for odd i.
REQ-010 State IDLE: if valid=1, limbs SHALL be captured sign-extended from in and FSM advances; if valid=0, FSM stays in IDLE.
REQ-011 QINIT (1 cycle): q SHALL be set to (19*h9 + 2^24) >>> 25.
REQ-012 QCHAIN (10 cycles, i=0..9 in order): q SHALL be set to (h_i + q) >>> w_i.
REQ-013 FOLD (1 cycle): h0 SHALL be set to h0 + 19*q.
REQ-014 CARRY (10 cycles, i=0..9 in order): c = h_i >>> w_i; h_i SHALL become h_i - (c << w_i); for i<9 h_{i+1} SHALL become h_{i+1} + c; for i=9, c SHALL be discarded.
REQ-015 After CARRY each h_i SHALL lie in [0, 2^w_i).
REQ-016 PACK (1 cycle): out SHALL be set to {1'b0, h9[24:0], h8[25:0], h7[24:0], h6[25:0], h5[24:0], h4[25:0], h3[24:0], h2[25:0], h1[24:0], h0[25:0]}; done SHALL be set to 1; FSM returns to IDLE.
REQ-017 Latency: valid sampled high at edge E0 SHALL yield done=1 in the cycle following edge E0+23; done SHALL be 0 in all other cycles.
REQ-018 valid SHALL be ignored while not in IDLE; no queuing; a new request is accepted at the earliest in the cycle after done.
REQ-019 Back-to-back: valid held high continuously SHALL produce one result every 24 cycles.
REQ-020 in is sampled only at the capture edge; later changes SHALL not affect the result in flight.
REQ-021 out SHALL hold its value between completions; bit 255 SHALL always be 0.
REQ-022 Correct result SHALL be guaranteed for |h_i| <= 2^27 on all limbs; behaviour outside this range is unspecified but SHALL not hang the FSM.
REQ-023 Any unused state encoding SHALL return to IDLE on the next edge.

Reset
REQ-024 On rst=1, asynchronously: FSM=IDLE, out=0, done=0; internal limbs and q may be left undefined.
REQ-025 rst asserted mid-operation SHALL abort the computation; no done pulse for the aborted request.
REQ-026 First valid SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-027 All limbs 0, valid pulse -> done at E0+23, out = 0.
REQ-028 in = p (h0=67108845, odd limbs 33554431, even limbs h2..h8 67108863) -> out = 0; p+1 (h0=67108846) -> out = 1.
REQ-029 2^255-1 (h0=67108863, others at max width) -> out = 18.
REQ-030 h0=-1, others 0 -> out = 256'h7FFF...FFEC (2^255-20); h0=2^26, others 0 -> out = 256'h4000000.
REQ-031 valid held high, three vectors changing every cycle -> exactly one done per 24 cycles, each result matches the vector present at its capture edge; toggling valid mid-computation has no effect.
REQ-032 rst pulsed at cycle 10 of a computation -> out=0 and done=0 immediately, no done for that request, next request after reset completes correctly in 24 cycles.
